ahb_lite_mem_arbiter: RTL and testbench

Two-client request arbiter and AHB-Lite master that shares the single-port AHB-Lite word memory slave between two simple valid/ready requesters. It converts each accepted client request into one AHB-Lite NONSEQ single transfer, word-sized. Address and data phases are pipelined, so the data phase of one transfer overlaps the address phase of the next. Read data, write completion and error status return to the issuing client on a per-client response strobe.

---
 rtl/ahb_lite_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ahb_lite_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_mem_arbiter.sv
// ahb_lite_mem_arbiter
// Two-client round-robin arbiter and AHB-Lite master for a single-port
// word memory slave. Each accepted client request becomes one NONSEQ
// single word transfer. The address and data phases are pipelined, so one
// transfer can be in its data phase while the next is in its address phase.
// Results go back to the issuing client on a one-cycle response strobe.
//
// Ports
//   HCLK, HRESETn             clock, asynchronous active-low reset
//   reqN_valid/ready/write/addr/wdata   client N request (ready is combinational)
//   rspN_valid/rdata/err      client N response strobe, read data, error flag
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA   AHB-Lite master outputs
//   HRDATA, HREADY, HRESP     AHB-Lite slave returns
module ahb_lite_mem_arbiter #(
    parameter logic [31:0] ADDR_MASK = 32'h0000_03FF,
    parameter logic [2:0]  HSIZE_VAL = 3'b010
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic        HSEL,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic        addr_busy;   // NONSEQ currently driven on the bus
    logic        addr_owner;
    logic [31:0] addr_wdata;  // write data waiting for its data phase
    logic        data_busy;   // a transfer is in its data phase
    logic        data_owner;
    logic        data_write;
    logic        last_grant;

    logic        slot_free;
    logic        grant0, grant1, accept;
    logic        acc_write;
    logic [31:0] acc_addr, acc_wdata;
    logic        resp_err;

    assign HSIZE = HSIZE_VAL;

    // Only bit0 of HRESP signals ERROR; the encodings 01 and 11 both carry it.
    assign resp_err = (HRESP == 2'b01) || (HRESP == 2'b11);

    always_comb begin
        slot_free = !addr_busy || HREADY;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (HRESETn && slot_free) begin
            if (req0_valid && req1_valid) begin
                // Round-robin: the client that did not win last time goes now.
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 || grant1;
    assign acc_write  = grant1 ? req1_write : req0_write;
    assign acc_addr   = grant1 ? req1_addr  : req0_addr;
    assign acc_wdata  = grant1 ? req1_wdata : req0_wdata;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_busy  <= 1'b0;
            addr_owner <= 1'b0;
            addr_wdata <= '0;
            data_busy  <= 1'b0;
            data_owner <= 1'b0;
            data_write <= 1'b0;
            last_grant <= 1'b1;
            HSEL       <= 1'b0;
            HADDR      <= '0;
            HTRANS     <= TRANS_IDLE;
            HWRITE     <= 1'b0;
            HWDATA     <= '0;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;

            // HREADY high ends both the data phase and the address phase.
            if (HREADY) begin
                if (data_busy) begin
                    if (data_owner) begin
                        rsp1_valid <= 1'b1;
                        rsp1_rdata <= data_write ? 32'h0 : HRDATA;
                        rsp1_err   <= resp_err;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_rdata <= data_write ? 32'h0 : HRDATA;
                        rsp0_err   <= resp_err;
                    end
                end
                data_busy <= addr_busy;
                if (addr_busy) begin
                    data_owner <= addr_owner;
                    data_write <= HWRITE;
                    HWDATA     <= addr_wdata;
                end
            end

            // A new accept overrides the return to IDLE, giving back-to-back NONSEQ.
            if (accept) begin
                addr_busy  <= 1'b1;
                addr_owner <= grant1;
                addr_wdata <= acc_wdata;
                last_grant <= grant1;
                HSEL       <= 1'b1;
                HTRANS     <= TRANS_NONSEQ;
                HADDR      <= acc_addr & ADDR_MASK;
                HWRITE     <= acc_write;
            end else if (slot_free) begin
                addr_busy <= 1'b0;
                HSEL      <= 1'b0;
                HTRANS    <= TRANS_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_mem_arbiter.sv
// Testbench for ahb_lite_mem_arbiter: directed scenarios plus randomized
// traffic against a word-memory slave model, with a queue-based scoreboard.
module tb_ahb_lite_mem_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
    logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        HSEL, HWRITE;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HRDATA = 0;
    logic        HREADY = 1'b1;
    logic [1:0]  HRESP = 2'b00;

    always #5 HCLK = ~HCLK;

    ahb_lite_mem_arbiter dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct { int owner; logic [31:0] rdata; logic err; int cyc; bit exact; } rsp_t;
    typedef struct { int owner; logic [31:0] addr; logic write; logic [31:0] wdata; logic err; } ap_t;

    rsp_t        rsp_q[$];
    ap_t         ap_q[$];
    int          acc_log[$];
    logic [31:0] smem[256];
    logic [31:0] ref_mem[256];
    int          checks = 0, errors = 0, cyc = 0;
    int          ref_last = 1;

    logic        c_hold[2], c_write[2];
    logic [31:0] c_addr[2], c_wdata[2];
    bit          acc[2];
    bit          hr_rec, nx_act, sd_act;
    ap_t         nx, sd;
    bit          rand_mode = 0, exact_lat = 0;
    int          p_req = 0, p_drop = 0, wait_pct = 0, stall_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // Response monitor: pops the scoreboard whenever a strobe appears.
    initial begin
        rsp_t e;
        int   n;
        forever begin
            @(posedge HCLK);
            cyc++;
            #1;
            if (HRESETn) begin
                chk("dual_rsp", {31'b0, rsp0_valid & rsp1_valid}, 0);
                if (rsp0_valid || rsp1_valid) begin
                    n = rsp1_valid ? 1 : 0;
                    if (rsp_q.size() == 0) fail_now("rsp_unexpected");
                    else begin
                        e = rsp_q.pop_front();
                        chk("rsp_owner", n, e.owner);
                        chk("rsp_rdata", n ? rsp1_rdata : rsp0_rdata, e.rdata);
                        chk("rsp_err", {31'b0, n ? rsp1_err : rsp0_err}, {31'b0, e.err});
                        if (e.exact) chk("rsp_latency", cyc - e.cyc, 2);
                        else         chk("rsp_latency_min", {31'b0, (cyc - e.cyc) >= 2}, 1);
                    end
                end
            end
        end
    end

    task automatic drive_inputs();
        req0_valid = c_hold[0]; req0_write = c_write[0]; req0_addr = c_addr[0]; req0_wdata = c_wdata[0];
        req1_valid = c_hold[1]; req1_write = c_write[1]; req1_addr = c_addr[1]; req1_wdata = c_wdata[1];
    endtask

    // Effects of the posedge just passed on the slave model.
    task automatic apply_edge();
        if (hr_rec) begin
            if (sd_act && sd.write && !sd.err) smem[sd.addr[9:2]] = sd.wdata;
            sd_act = nx_act;
            sd     = nx;
        end
    endtask

    task automatic accept_model(input int n);
        logic [31:0] masked, rd;
        logic        err;
        masked = c_addr[n] & 32'h0000_03FF;
        err    = masked >= 32'h0000_03E0;
        ap_q.push_back('{n, masked, c_write[n], c_wdata[n], err});
        rd = c_write[n] ? 32'h0 : ref_mem[masked[9:2]];
        if (c_write[n] && !err) ref_mem[masked[9:2]] = c_wdata[n];
        rsp_q.push_back('{n, rd, err, cyc + 1, exact_lat});
        ref_last = n;
        acc_log.push_back(n);
    endtask

    // Pre-edge sampling: bus checks, arbitration checks, acceptance into the model.
    task automatic record();
        bit slot, e0, e1;
        hr_rec = HREADY;
        nx_act = 0;
        chk("hsize", {29'b0, HSIZE}, 3'b010);
        chk("hsel_vs_htrans", {31'b0, HSEL}, {31'b0, HTRANS == 2'b10});
        if (HTRANS == 2'b10) begin
            if (ap_q.size() == 0) fail_now("addr_phase_unexpected");
            else begin
                chk("haddr", HADDR, ap_q[0].addr);
                chk("hwrite", {31'b0, HWRITE}, {31'b0, ap_q[0].write});
                if (HREADY) begin
                    nx     = ap_q.pop_front();
                    nx_act = 1;
                end
            end
        end else begin
            chk("htrans_idle", {30'b0, HTRANS}, 0);
            chk("addr_q_idle", ap_q.size(), 0);
        end
        if (sd_act && sd.write) chk("hwdata", HWDATA, sd.wdata);
        slot = (HTRANS != 2'b10) || HREADY;
        e0 = slot && req0_valid && (!req1_valid || ref_last == 1);
        e1 = slot && req1_valid && (!req0_valid || ref_last == 0);
        chk("ready", {30'b0, req1_ready, req0_ready}, {30'b0, e1, e0});
        acc[0] = req0_valid && req0_ready;
        acc[1] = req1_valid && req1_ready;
        for (int n = 0; n < 2; n++) if (acc[n]) begin
            accept_model(n);
            c_hold[n] = 0;
        end
    endtask

    task automatic step();
        @(negedge HCLK);
        apply_edge();
        if (rand_mode) begin
            for (int n = 0; n < 2; n++) begin
                if (c_hold[n]) begin
                    if ($urandom_range(0, 99) < p_drop) c_hold[n] = 0;
                end else if ($urandom_range(0, 99) < p_req) begin
                    c_hold[n]  = 1;
                    c_write[n] = 1'($urandom_range(0, 1));
                    c_addr[n]  = $urandom & 32'h0000_1FFC;
                    c_wdata[n] = $urandom;
                end
            end
        end
        drive_inputs();
        HREADY = 1'b1;
        if (sd_act) begin
            if (stall_left > 0) begin
                HREADY = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 99) < wait_pct) HREADY = 1'b0;
        end
        HRDATA = (sd_act && !sd.write) ? smem[sd.addr[9:2]] : $urandom;
        HRESP  = (sd_act && sd.err) ? 2'b01 : 2'b00;
        #1;
        record();
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        apply_edge();
        HRESETn = 1'b0;
        c_hold = '{0, 0};
        drive_inputs();
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
        ap_q.delete(); rsp_q.delete();
        sd_act = 0; nx_act = 0; hr_rec = 0; acc = '{0, 0};
        stall_left = 0; ref_last = 1;
        for (int i = 0; i < 256; i++) ref_mem[i] = smem[i];
        #1;
        chk("rst_bus", {HSEL, HTRANS, HWRITE}, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_hsize", {29'b0, HSIZE}, 3'b010);
        chk("rst_ctl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 0);
        chk("rst_rdata", rsp0_rdata | rsp1_rdata, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic issue(input int n, input logic w, input logic [31:0] a, input logic [31:0] d);
        bit got = 0;
        c_hold[n] = 1; c_write[n] = w; c_addr[n] = a; c_wdata[n] = d;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = acc[n];
        end
        if (!got) fail_now("issue_timeout");
    endtask

    task automatic drain();
        int i = 0;
        rand_mode = 0;
        while (i < 200 && (rsp_q.size() != 0 || ap_q.size() != 0 || sd_act || nx_act
                           || c_hold[0] || c_hold[1])) begin
            step();
            i++;
        end
        if (i >= 200) fail_now("drain_timeout");
    endtask

    initial begin
        c_hold = '{0, 0}; c_write = '{0, 0}; c_addr = '{0, 0}; c_wdata = '{0, 0};
        for (int i = 0; i < 256; i++) smem[i] = $urandom;
        do_reset();

        // Write then read back with zero wait states, exact latency.
        exact_lat = 1; wait_pct = 0;
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF);
        issue(0, 1'b0, 32'h10, 32'h0);
        drain();
        chk("mem_0x10", smem[4], 32'hDEADBEEF);

        // Address masking.
        issue(0, 1'b0, 32'h0000_1404, 32'h0);
        drain();

        // Error response on a client 1 read, and an errored write is not stored.
        issue(1, 1'b0, 32'h3F0, 32'h0);
        issue(0, 1'b1, 32'h3E4, 32'h12345678);
        issue(0, 1'b0, 32'h3E4, 32'h0);
        drain();

        // Both clients saturating: 8 accepts in 8 cycles, alternating from 0.
        do_reset();
        acc_log.delete();
        rand_mode = 1; p_req = 100; p_drop = 0;
        for (int i = 0; i < 8; i++) step();
        rand_mode = 0;
        chk("sat_accepts", acc_log.size(), 8);
        for (int i = 0; i < acc_log.size() && i < 8; i++) chk("sat_grant_order", acc_log[i], i % 2);
        c_hold = '{0, 0};
        drain();

        // Write data phase stalled 3 cycles with a read behind it and client 0 waiting.
        exact_lat = 0;
        stall_left = 3;
        issue(0, 1'b1, 32'h40, 32'hA5A5_0F0F);
        issue(1, 1'b0, 32'h40, 32'h0);
        c_hold[0] = 1; c_write[0] = 0; c_addr[0] = 32'h80;
        drain();

        // Reset while a read sits in its data phase: dropped, no response.
        stall_left = 6;
        issue(0, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 5 && !sd_act; i++) step();
        chk("mid_read_in_data_phase", {31'b0, sd_act}, 1);
        do_reset();
        for (int i = 0; i < 4; i++) step();
        c_hold = '{1, 1}; c_write = '{0, 0}; c_addr = '{32'h24, 32'h28};
        step();
        chk("post_reset_grant", {30'b0, acc[1], acc[0]}, 2'b01);
        drain();

        // Randomized traffic with wait states, drops and occasional resets.
        rand_mode = 1; p_req = 60; p_drop = 5; wait_pct = 25;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            rand_mode = 1;
            step();
        end
        c_hold = '{0, 0};
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
